// File: rtl/brs_rr_arbiter_pkg.sv
// Shared constants and types for the round-robin arbiter slice.
package brs_arb_pkg;

    localparam int unsigned NUM_REQ = 16;
    localparam int unsigned IDX_W = 4;

    // Encoder code reported on status when no grant is active.
    localparam logic [7:0] IDLE_CODE = 8'hF0;

    typedef enum logic {
        ST_IDLE,
        ST_GRANT
    } state_t;

endpackage

// File: rtl/brs_rr_arbiter_if.sv
// Request/grant bundle between requesters (master) and the arbiter (slave).
interface brs_rr_arbiter_if;
    import brs_arb_pkg::*;

    logic [NUM_REQ-1:0] req;
    logic               release_i;
    logic               grant_valid;
    logic [IDX_W-1:0]   grant_idx;
    logic [NUM_REQ-1:0] grant_onehot;
    logic [7:0]         status;
    logic               timeout;

    modport master (
        output req,
        output release_i,
        input  grant_valid,
        input  grant_idx,
        input  grant_onehot,
        input  status,
        input  timeout
    );

    modport slave (
        input  req,
        input  release_i,
        output grant_valid,
        output grant_idx,
        output grant_onehot,
        output status,
        output timeout
    );

endinterface

// File: rtl/brs_rr_arbiter_prio_enc.sv
// 16-bit most-significant-first priority encoder (combinational).
module brs_prio_enc16
    import brs_arb_pkg::*;
(
    input  logic [15:0]      vec,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    // Ascending scan so the highest set bit is the last one written.
    always_comb begin
        idx = '0;
        valid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (vec[i]) begin
                idx = IDX_W'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/brs_rr_arbiter.sv
// Round-robin arbiter: rotating priority, grant held until release, request drop
// or hold limit, then one idle bubble before re-arbitration.
module brs_rr_arbiter
    import brs_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 16,
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic             clk,
    input  logic             rst,
    brs_rr_arbiter_if.slave  bus
);

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   top_q, top_d;
    logic [7:0]         hold_cnt_q, hold_cnt_d;
    logic               grant_valid_q, grant_valid_d;
    logic [IDX_W-1:0]   grant_idx_q, grant_idx_d;
    logic [NUM_REQ-1:0] grant_onehot_q, grant_onehot_d;
    logic [7:0]         status_q, status_d;
    logic               timeout_q, timeout_d;

    logic [NUM_REQ-1:0] req_rot;
    logic [IDX_W-1:0]   enc_idx;
    logic               enc_valid;
    logic [IDX_W-1:0]   win_idx;
    logic               exit_grant;

    // Rotate req so bit top lands on bit 15; search then runs top, top-1, ...
    always_comb begin
        req_rot = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            req_rot[j] = bus.req[IDX_W'(j) + top_q + 4'd1];
        end
    end

    brs_prio_enc16 u_enc (
        .vec   (req_rot),
        .idx   (enc_idx),
        .valid (enc_valid)
    );

    // Undo the rotation to get the absolute winner index.
    assign win_idx = enc_idx + top_q + 4'd1;

    // Next-state and registered-output logic.
    always_comb begin
        state_d        = state_q;
        top_d          = top_q;
        hold_cnt_d     = hold_cnt_q;
        grant_valid_d  = grant_valid_q;
        grant_idx_d    = grant_idx_q;
        grant_onehot_d = grant_onehot_q;
        timeout_d      = 1'b0;
        exit_grant     = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (enc_valid) begin
                    state_d        = ST_GRANT;
                    grant_valid_d  = 1'b1;
                    grant_idx_d    = win_idx;
                    grant_onehot_d = NUM_REQ'(1) << win_idx;
                    hold_cnt_d     = '0;
                    // The new owner drops to lowest priority.
                    top_d          = win_idx - 4'd1;
                end
            end
            ST_GRANT: begin
                if (bus.release_i) begin
                    exit_grant = 1'b1;
                end else if (!bus.req[grant_idx_q]) begin
                    exit_grant = 1'b1;
                end else if (hold_cnt_q == 8'(MAX_HOLD - 1)) begin
                    exit_grant = 1'b1;
                    timeout_d  = 1'b1;
                end else begin
                    hold_cnt_d = hold_cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (exit_grant) begin
            state_d        = ST_IDLE;
            grant_valid_d  = 1'b0;
            grant_idx_d    = '0;
            grant_onehot_d = '0;
        end

        status_d = grant_valid_d ? {4'b0, grant_idx_d} : IDLE_CODE;
    end

    // State, pointer, counter and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            top_q          <= 4'd15;
            hold_cnt_q     <= '0;
            grant_valid_q  <= 1'b0;
            grant_idx_q    <= '0;
            grant_onehot_q <= '0;
            status_q       <= IDLE_CODE;
            timeout_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            top_q          <= top_d;
            hold_cnt_q     <= hold_cnt_d;
            grant_valid_q  <= grant_valid_d;
            grant_idx_q    <= grant_idx_d;
            grant_onehot_q <= grant_onehot_d;
            status_q       <= status_d;
            timeout_q      <= timeout_d;
        end
    end

    assign bus.grant_valid  = grant_valid_q;
    assign bus.grant_idx    = grant_idx_q;
    assign bus.grant_onehot = grant_onehot_q;
    assign bus.status       = status_q;
    assign bus.timeout      = timeout_q;

endmodule

// File: tb/tb_brs_rr_arbiter.sv
// Directed bench for brs_rr_arbiter: vector table plus hand-written corner sequences.
module tb_brs_rr_arbiter;

    typedef struct {
        logic        rst;
        logic [15:0] req;
        logic        rel;
        logic        ev;
        logic [3:0]  ei;
        logic        et;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    brs_rr_arbiter_if bus ();

    brs_rr_arbiter #(
        .NUM_REQ  (16),
        .MAX_HOLD (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int   n_tests = 0;
    int   n_fail = 0;
    vec_t vecs[$];

    function automatic void add(input logic r, input logic [15:0] rq, input logic rel,
                                input logic ev, input logic [3:0] ei, input logic et);
        vec_t v;
        v.rst = r;
        v.req = rq;
        v.rel = rel;
        v.ev  = ev;
        v.ei  = ei;
        v.et  = et;
        vecs.push_back(v);
    endfunction

    // Drive one cycle of inputs, clock, then compare all outputs after the edge.
    task automatic step(input logic r, input logic [15:0] rq, input logic rel,
                        input logic ev, input logic [3:0] ei, input logic et,
                        input string name);
        logic [15:0] eoh;
        logic [7:0]  est;
        logic [29:0] exp_v;
        logic [29:0] act_v;
        rst = r;
        bus.req = rq;
        bus.release_i = rel;
        @(posedge clk);
        #1;
        eoh = ev ? (16'h0001 << ei) : 16'h0000;
        est = ev ? {4'h0, ei} : 8'hF0;
        exp_v = {ev, ei, eoh, est, et};
        act_v = {bus.grant_valid, bus.grant_idx, bus.grant_onehot, bus.status, bus.timeout};
        n_tests++;
        if (act_v !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got v=%0b idx=%0d oh=%h st=%h to=%0b, want v=%0b idx=%0d oh=%h st=%h to=%0b",
                     name, bus.grant_valid, bus.grant_idx, bus.grant_onehot, bus.status,
                     bus.timeout, ev, ei, eoh, est, et);
        end
    endtask

    initial begin
        bus.req = '0;
        bus.release_i = 1'b0;

        // Reset, then idle with release toggling (ignored in IDLE).
        add(1, 16'h0000, 0, 0, 0, 0);
        add(1, 16'h0000, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) add(0, 16'h0000, 1'(i % 2), 0, 0, 0);

        // 8001 held, release on grant cycle 3: 15, 0, 15, 0.
        for (int g = 0; g < 4; g++) begin
            logic [3:0] k;
            k = (g % 2 == 0) ? 4'd15 : 4'd0;
            add(0, 16'h8001, 0, 1, k, 0);
            add(0, 16'h8001, 0, 1, k, 0);
            add(0, 16'h8001, 0, 1, k, 0);
            add(0, 16'h8001, 1, 0, 0, 0);
        end
        add(0, 16'h0000, 0, 0, 0, 0);

        // All requesting, release in first grant cycle: 15 down to 0, then 15.
        for (int k = 15; k >= 0; k--) begin
            add(0, 16'hFFFF, 0, 1, 4'(k), 0);
            add(0, 16'hFFFF, 1, 0, 0, 0);
        end
        add(0, 16'hFFFF, 0, 1, 4'd15, 0);
        add(0, 16'h0000, 0, 0, 0, 0);

        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].req, vecs[i].rel, vecs[i].ev, vecs[i].ei, vecs[i].et,
                 $sformatf("vec%0d", i));
        end

        // Hold limit: 8 grant cycles to 4, timeout bubble, re-grant.
        for (int c = 0; c < 8; c++) step(0, 16'h0010, 0, 1, 4'd4, 0, $sformatf("hold_c%0d", c));
        step(0, 16'h0010, 0, 0, 4'd0, 1, "timeout_bubble");
        step(0, 16'h0010, 0, 1, 4'd4, 0, "regrant_4");
        step(0, 16'h0010, 1, 0, 4'd0, 0, "release_4");

        // Owner 7 drops its request; no preemption by 3 before that.
        step(0, 16'h0080, 0, 1, 4'd7, 0, "grant_7");
        step(0, 16'h0088, 0, 1, 4'd7, 0, "no_preempt");
        step(0, 16'h0008, 0, 0, 4'd0, 0, "drop_bubble");
        step(0, 16'h0008, 0, 1, 4'd3, 0, "grant_3");
        // Release exactly at hold_cnt = MAX_HOLD-1: no timeout.
        for (int c = 0; c < 7; c++) step(0, 16'h0008, 0, 1, 4'd3, 0, $sformatf("hold3_c%0d", c));
        step(0, 16'h0008, 1, 0, 4'd0, 0, "rel_at_limit");
        step(0, 16'h0000, 0, 0, 4'd0, 0, "no_timeout");

        // Reset in grant cycle 2; top back to 15 so bit 2 beats bit 0.
        step(0, 16'h0005, 0, 1, 4'd2, 0, "grant_2");
        step(0, 16'h0005, 0, 1, 4'd2, 0, "grant_2_c2");
        step(1, 16'h0005, 0, 0, 4'd0, 0, "mid_reset");
        step(0, 16'h0005, 0, 1, 4'd2, 0, "post_reset_grant");
        step(0, 16'h0005, 1, 0, 4'd0, 0, "post_reset_release");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/brs_rr_arbiter.md
# brs_rr_arbiter

Round-robin arbiter that shares one downstream resource among 16 requesters. Each cycle it picks a winner with a rotating 16-bit most-significant-first priority encoder. It holds the grant until the owner releases it, drops its request, or exceeds a hold limit. It then inserts one idle cycle and re-arbitrates. Its `status` byte uses the team's encoder code convention: winner index 0–15, or 8'hF0 when nothing is granted.

## Interface
- `NUM_REQ`, 16, number of requesters. Fixed at 16 for this revision.
- `MAX_HOLD`, 8, maximum consecutive grant cycles, legal range 1–255.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req` in 16: request vector, bit i = requester i.
- `release_i` in 1: owner releases the current grant this cycle.
- `grant_valid` out 1: a grant is active.
- `grant_idx` out 4: index of the current owner. 0 when `grant_valid`=0.
- `grant_onehot` out 16: one-hot of the owner. All zeros when idle.
- `status` out 8: {4'b0, `grant_idx`} when granted, 8'hF0 when idle.
- `timeout` out 1: one-cycle pulse when a grant is revoked by the hold limit.

## Operation
- States: IDLE and GRANT. All outputs are registered.
- Priority pointer `top` (4 bits):
  - Reset value 15.
  - Search order is `top`, `top`−1, … mod 16 (descending, wrapping 0→15).
  - On each new grant to index k, `top` becomes (k−1) mod 16, so k becomes lowest priority.
- IDLE:
  - If `req` != 0: select the first set bit in search order, go to GRANT, load `grant_idx`/`grant_onehot`, clear `hold_cnt` to 0, update `top`.
  - If `req` == 0: stay in IDLE; `top` is unchanged.
- GRANT, each cycle, in priority order:
  - (a) `release_i`=1 → IDLE.
  - (b) `req[grant_idx]`=0 → IDLE (implicit release).
  - (c) `hold_cnt` == MAX_HOLD−1 → IDLE, `timeout` pulses on the next cycle.
  - (d) otherwise stay and increment `hold_cnt`.
- Release and timeout in the same cycle: release wins and `timeout` stays 0.
- `release_i` is ignored in IDLE.
- Requests from non-owners never preempt the owner.
- `hold_cnt` is 8 bits and never wraps, because exit (c) always occurs first.
- Reset values:
  - `grant_valid`=0, `grant_idx`=0, `grant_onehot`=0, `status`=8'hF0, `timeout`=0.
  - State IDLE, `top`=15, `hold_cnt`=0.
- Reset asserted mid-grant: outputs take their reset values at the next edge, the grant is lost, and no `timeout` pulse is emitted.

## Timing
- `req` sampled in IDLE at edge t → `grant_valid`=1 from cycle t+1.
- Grant exit decided at edge t → `grant_valid`=0 in cycle t+1 (the IDLE bubble). Earliest next grant is cycle t+2.
- Back-to-back grants are always separated by exactly one idle cycle.
- Maximum grant length is MAX_HOLD cycles.
- `timeout` is high only during the bubble cycle that follows a limit revocation.
- `status`, `grant_idx` and `grant_onehot` change on the same edge as `grant_valid`.

## Structure
- Package `brs_arb_pkg` holds:
  - `NUM_REQ`=16 and `IDX_W`=4
  - `IDLE_CODE`=8'hF0
  - state enum {ST_IDLE, ST_GRANT}
- Sub-module `brs_prio_enc16` is combinational:
  - Input: 16-bit vector. Outputs: 4-bit index of the highest set bit, plus a valid flag.
  - The arbiter rotates `req` so that bit `top` maps to bit 15, encodes the rotated vector, then un-rotates the index: idx = (enc + `top` + 1) mod 16.
- The arbiter top holds the FSM, `top`, `hold_cnt` and the output registers.

## Test plan
- Reset then `req`=0 for 5 cycles → `status`=8'hF0, `grant_valid`=0 and `timeout`=0 throughout.
- `req`=16'h8001 held, `release_i` pulsed on cycle 3 of each grant → grants to 15, 0, 15, 0, each separated by one cycle with `status`=8'hF0.
- All 16 requests held, `release_i`=1 in the first grant cycle every time → grant order 15, 14, …, 0, 15, with one-hot and index consistent each time.
- `req`=16'h0010 held, no release, MAX_HOLD=8:
  - Grant to 4 for exactly 8 cycles, then `grant_valid`=0 with `timeout`=1 for one cycle.
  - Re-grant to 4 on the following cycle.
- Owner 7 drops `req[7]` while `req[3]` is high → one bubble cycle, then grant to 3. Also assert `release_i` in the cycle where `hold_cnt`=MAX_HOLD−1 → `timeout` stays 0.
- Assert `rst` in grant cycle 2 → next cycle all outputs at reset values and `top`=15. The first grant afterwards goes to the highest set bit.
